// File: rtl/fact_pkg.sv
// Shared definitions for the memory-mapped factorial accelerator:
// FSM encoding, register offsets and the default operand limit.
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam logic [1:0] A_N      = 2'd0;
    localparam logic [1:0] A_GO     = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_RESULT = 2'd3;

    // 12! is the largest factorial representable in 32 bits
    localparam int MAX_N_DEF = 12;

endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: down-counter, running product and the
// DATA_W x N_W multiplier truncated to DATA_W.
module fact_dp
    import fact_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [N_W-1:0]    n_i,
    output logic [DATA_W-1:0] prod_o,
    output logic              cnt_le1_o
);

    logic [DATA_W-1:0] prod_q, prod_d;
    logic [N_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] mul_w;

    assign mul_w = prod_q * DATA_W'(cnt_q);

    always_comb begin
        prod_d = prod_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            prod_d = DATA_W'(1);
            cnt_d  = n_i;
        end else if (step_i) begin
            prod_d = mul_w;
            cnt_d  = cnt_q - N_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            cnt_q  <= '0;
        end else begin
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
        end
    end

    assign prod_o    = prod_q;
    assign cnt_le1_o = (cnt_q <= N_W'(1));

endmodule

// File: rtl/fact_mmio_responder.sv
// Memory-mapped factorial accelerator: register file, same-cycle
// read mux and control FSM around the fact_dp datapath.
module fact_mmio_responder
    import fact_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 4,
    parameter int MAX_N  = MAX_N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    localparam logic [N_W-1:0] MAX_N_W = N_W'(MAX_N);

    state_e            state_q, state_d;
    logic [N_W-1:0]    n_reg_q, n_reg_d;
    logic              go_reg_q, go_reg_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              start;
    logic              load;
    logic              step;
    logic [DATA_W-1:0] prod;
    logic              cnt_le1;
    logic              wd_unused;

    assign wd_unused = ^wd[DATA_W-1:N_W];

    // A GO while computing only updates go_reg; the run continues
    assign start = we && (a == A_GO) && wd[0] && (state_q != CALC);

    always_comb begin
        state_d  = state_q;
        n_reg_d  = n_reg_q;
        go_reg_d = go_reg_q;
        done_d   = done_q;
        err_d    = err_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;

        if (we) begin
            unique case (a)
                A_N:     n_reg_d  = wd[N_W-1:0];
                A_GO:    go_reg_d = wd[0];
                default: ;
            endcase
        end

        unique case (state_q)
            CALC: begin
                if (cnt_le1) begin
                    result_d = prod;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    if (n_reg_q > MAX_N_W) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                        load    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            n_reg_q  <= '0;
            go_reg_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            n_reg_q  <= n_reg_d;
            go_reg_q <= go_reg_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        rd = '0;
        unique case (a)
            A_N:      rd = DATA_W'(n_reg_q);
            A_GO:     rd = DATA_W'(go_reg_q);
            A_STATUS: rd = DATA_W'({err_q, done_q});
            A_RESULT: rd = result_q;
            default:  rd = '0;
        endcase
    end

    fact_dp #(
        .DATA_W (DATA_W),
        .N_W    (N_W)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .step_i    (step),
        .n_i       (n_reg_q),
        .prod_o    (prod),
        .cnt_le1_o (cnt_le1)
    );

endmodule

// File: tb/tb_fact_mmio_responder.sv
// Self-checking bench for fact_mmio_responder: directed boundary
// cases plus random operands against a factorial reference model.
module tb_fact_mmio_responder;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;

    fact_mmio_responder #(
        .DATA_W (32),
        .N_W    (4),
        .MAX_N  (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .a   (a),
        .wd  (wd),
        .rd  (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_fact(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int k = 2; k <= n; k++) p = p * 32'(k);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(posedge clk);
        #1;
        we = 1'b0;
        wd = '0;
    endtask

    task automatic rdreg(input logic [1:0] addr, output logic [31:0] v);
        we = 1'b0;
        a  = addr;
        #1;
        v = rd;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] addr,
                           input logic [31:0] exp);
        logic [31:0] v;
        rdreg(addr, v);
        chk(tag, v, exp);
    endtask

    // Poll STATUS each edge; report edges taken, bounded by budget
    task automatic wait_done(input int budget, output int edges);
        logic [31:0] v;
        edges = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            rdreg(2'd2, v);
            if (v[0]) begin
                edges = k;
                break;
            end
        end
    endtask

    // Full transaction checked against the reference: every poll
    // before max(n,1) edges must read 0, then exactly done.
    task automatic run_n(input string tag, input int n);
        int          lat;
        logic [31:0] v;
        wr(2'd0, 32'(n));
        chk_reg({tag, ".n"}, 2'd0, 32'(n));
        wr(2'd1, 32'd1);
        if (n > 12) begin
            chk_reg({tag, ".errstat"}, 2'd2, 32'd3);
            chk_reg({tag, ".errres"}, 2'd3, 32'd0);
        end else begin
            lat = (n < 1) ? 1 : n;
            chk_reg({tag, ".busy0"}, 2'd2, 32'd0);
            for (int k = 1; k <= lat; k++) begin
                tick();
                rdreg(2'd2, v);
                if (k < lat) begin
                    if (v !== 32'd0) chk({tag, ".busy"}, v, 32'd0);
                end else begin
                    chk({tag, ".done"}, v, 32'd1);
                end
            end
            chk_reg({tag, ".res"}, 2'd3, ref_fact(n));
        end
    endtask

    initial begin
        int          e;
        int          n;
        logic [31:0] v;

        rst = 1'b1;
        we  = 1'b0;
        a   = '0;
        wd  = '0;
        #12;
        chk_reg("rst.n", 2'd0, 32'd0);
        chk_reg("rst.go", 2'd1, 32'd0);
        chk_reg("rst.stat", 2'd2, 32'd0);
        chk_reg("rst.res", 2'd3, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // async reset mid-cycle while computing
        wr(2'd0, 32'd7);
        wr(2'd1, 32'd1);
        tick();
        #2;
        rst = 1'b1;
        chk_reg("arst.n", 2'd0, 32'd0);
        chk_reg("arst.go", 2'd1, 32'd0);
        chk_reg("arst.stat", 2'd2, 32'd0);
        chk_reg("arst.res", 2'd3, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_n("n5", 5);
        run_n("n0", 0);
        run_n("n1", 1);
        run_n("n12", 12);

        // writes to STATUS/RESULT are ignored; GO=0 changes nothing
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'h1234_5678);
        chk_reg("ro.stat", 2'd2, 32'd1);
        chk_reg("ro.res", 2'd3, 32'd479001600);
        wr(2'd1, 32'd0);
        chk_reg("go0.go", 2'd1, 32'd0);
        tick();
        chk_reg("go0.stat", 2'd2, 32'd1);

        run_n("n13", 13);
        tick();
        chk_reg("errhold", 2'd2, 32'd3);
        run_n("n3", 3);

        // N and GO written mid-computation
        wr(2'd0, 32'd6);
        wr(2'd1, 32'd1);
        tick();
        wr(2'd0, 32'd2);
        wr(2'd1, 32'd1);
        chk_reg("mid.go", 2'd1, 32'd1);
        chk_reg("mid.n", 2'd0, 32'd2);
        wait_done(20, e);
        chk("mid.edges", 32'(e), 32'd3);
        chk_reg("mid.res", 2'd3, 32'd720);
        wr(2'd1, 32'd1);
        wait_done(20, e);
        chk("re.edges", 32'(e), 32'd2);
        chk_reg("re.res", 2'd3, 32'd2);

        // reset on the third computation edge of n=10
        wr(2'd0, 32'd10);
        wr(2'd1, 32'd1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        chk_reg("r3.stat", 2'd2, 32'd0);
        chk_reg("r3.res", 2'd3, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr(2'd1, 32'd1);
        wait_done(20, e);
        chk("r3.edges", 32'(e), 32'd1);
        chk_reg("r3.fres", 2'd3, 32'd1);

        for (int i = 0; i < 24; i++) begin
            n = int'($urandom_range(0, 15));
            run_n($sformatf("rnd%0d", i), n);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                rdreg(2'd2, v);
                chk($sformatf("rnd%0d.hold", i), v,
                    (n > 12) ? 32'd3 : 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
